// File: rtl/trigger_conditioner.sv
// External trigger front-end: synchronizer, inversion, stability filter,
// post-edge hold-off, edge pulses and a saturating glitch counter.
module trigger_conditioner #(
  parameter int FILTER_W  = 4,
  parameter int HOLDOFF_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger_pin,
  input  logic                 is_invert,
  input  logic [FILTER_W-1:0]  filter_len,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 glitch_clear,
  output logic                 trigger,
  output logic                 rising_pulse,
  output logic                 falling_pulse,
  output logic [7:0]           glitch_count,
  output logic                 is_holdoff
);

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    HOLDOFF
  } state_e;

  state_e               state_q;
  logic                 sync0_q;
  logic                 sync1_q;
  logic                 trig_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 hold_q;
  logic [7:0]           glitch_q;
  logic [FILTER_W-1:0]  cnt_q;
  logic [HOLDOFF_W-1:0] hcnt_q;

  logic                 s;
  logic                 differ;
  logic                 accept;
  logic                 glitch;
  logic [FILTER_W-1:0]  cnt_eval;
  logic [FILTER_W-1:0]  cnt_d;

  always_comb begin
    s        = sync1_q ^ is_invert;
    differ   = s != trig_q;
    // IDLE evaluates a new candidate in the same cycle with a zero count
    cnt_eval = (state_q == IDLE) ? '0 : cnt_q;
    accept   = (state_q != HOLDOFF) && differ
               && (cnt_eval >= filter_len);
    glitch   = (state_q == QUALIFY) && !differ;
    cnt_d    = (cnt_eval == '1) ? cnt_eval
                                : cnt_eval + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      trig_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      hold_q   <= 1'b0;
      glitch_q <= '0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
    end else begin
      sync0_q <= trigger_pin;
      sync1_q <= sync0_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;

      if (glitch_clear) begin
        glitch_q <= '0;
      end else if (glitch && glitch_q != 8'hff) begin
        glitch_q <= glitch_q + 8'd1;
      end

      unique case (state_q)
        IDLE, QUALIFY: begin
          if (accept) begin
            trig_q <= s;
            rise_q <= s;
            fall_q <= ~s;
            cnt_q  <= '0;
            hcnt_q <= holdoff;
            if (holdoff != '0) begin
              state_q <= HOLDOFF;
              hold_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (differ) begin
            state_q <= QUALIFY;
            cnt_q   <= cnt_d;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        HOLDOFF: begin
          cnt_q  <= '0;
          hcnt_q <= hcnt_q - 1'b1;
          if (hcnt_q <= HOLDOFF_W'(1)) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign trigger       = trig_q;
  assign rising_pulse  = rise_q;
  assign falling_pulse = fall_q;
  assign glitch_count  = glitch_q;
  assign is_holdoff    = hold_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Randomized bench for trigger_conditioner against a run-length /
// hold-off-timer model of the trigger conditioning rules.
module tb_trigger_conditioner;

  localparam int FW = 4;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trigger_pin;
  logic          is_invert;
  logic [FW-1:0] filter_len;
  logic [HW-1:0] holdoff;
  logic          glitch_clear;
  logic          trigger;
  logic          rising_pulse;
  logic          falling_pulse;
  logic [7:0]    glitch_count;
  logic          is_holdoff;

  int errors = 0;
  int checks = 0;

  // model state
  int m_p1, m_p2, m_trig, m_run, m_hold, m_glitch;
  int m_rise, m_fall;

  trigger_conditioner #(.FILTER_W(FW), .HOLDOFF_W(HW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger_pin  (trigger_pin),
    .is_invert    (is_invert),
    .filter_len   (filter_len),
    .holdoff      (holdoff),
    .glitch_clear (glitch_clear),
    .trigger      (trigger),
    .rising_pulse (rising_pulse),
    .falling_pulse(falling_pulse),
    .glitch_count (glitch_count),
    .is_holdoff   (is_holdoff)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_trig = 0; m_run = 0;
    m_hold = 0; m_glitch = 0; m_rise = 0; m_fall = 0;
  endtask

  // one clock edge of the conditioning rules
  task automatic model_edge();
    int s;
    bit gl;
    s  = m_p2 ^ int'(is_invert);
    gl = 0;
    m_rise = 0;
    m_fall = 0;
    if (m_hold > 0) begin
      m_hold--;
      m_run = 0;
    end else if (s != m_trig) begin
      if (m_run >= int'(filter_len)) begin
        m_trig = s;
        m_rise = s;
        m_fall = 1 - s;
        m_hold = int'(holdoff);
        m_run  = 0;
      end else if (m_run < (1 << FW) - 1) begin
        m_run++;
      end
    end else begin
      gl    = (m_run > 0);
      m_run = 0;
    end
    if (glitch_clear) m_glitch = 0;
    else if (gl && m_glitch < 255) m_glitch++;
    m_p2 = m_p1;
    m_p1 = int'(trigger_pin);
  endtask

  task automatic compare();
    chk("trigger", int'(trigger), m_trig);
    chk("rising", int'(rising_pulse), m_rise);
    chk("falling", int'(falling_pulse), m_fall);
    chk("glitches", int'(glitch_count), m_glitch);
    chk("holdoff", int'(is_holdoff), int'(m_hold > 0));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    trigger_pin  = 1'b0;
    is_invert    = 1'b0;
    filter_len   = 4'd3;
    holdoff      = 8'd0;
    glitch_clear = 1'b0;
    model_reset();

    // reset held while the pin toggles
    for (int i = 0; i < 6; i++) begin
      trigger_pin = ~trigger_pin;
      step();
    end
    trigger_pin = 1'b0;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n += int'(rising_pulse) + int'(falling_pulse);
    end
    chk("no_pulse_after_reset", n, 0);

    // clean rising edge latency
    trigger_pin = 1'b1;
    step();
    n = 0;
    while (!rising_pulse && n < 50) begin
      step();
      n++;
    end
    chk("rise_latency", n, 2 + 3);
    chk("rise_level", int'(trigger), 1);
    trigger_pin = 1'b0;
    repeat (10) step();

    // short glitch rejected
    trigger_pin = 1'b1;
    repeat (2) step();
    trigger_pin = 1'b0;
    repeat (8) step();
    chk("glitch_one", int'(glitch_count), 1);
    chk("glitch_trig", int'(trigger), 0);

    // zero filter accepts a 1-cycle pulse
    filter_len  = 4'd0;
    trigger_pin = 1'b1;
    step();
    trigger_pin = 1'b0;
    repeat (6) step();
    chk("f0_trig_back", int'(trigger), 0);

    // hold-off masks an early falling edge
    filter_len  = 4'd1;
    holdoff     = 8'd10;
    trigger_pin = 1'b1;
    n = 0;
    while (!rising_pulse && n < 50) begin
      step();
      n++;
    end
    chk("ho_rise_seen", int'(rising_pulse), 1);
    n = 0;
    repeat (3) begin
      step();
      n++;
    end
    trigger_pin = 1'b0;
    while (!falling_pulse && n < 60) begin
      step();
      n++;
    end
    chk("ho_fall_delay", n, 12);
    chk("ho_glitches", int'(glitch_count), 1);

    // glitch counter saturation
    holdoff    = 8'd0;
    filter_len = 4'd3;
    repeat (5) step();
    for (int i = 0; i < 600; i++) begin
      trigger_pin = ~trigger_pin;
      step();
    end
    trigger_pin = 1'b0;
    repeat (6) step();
    chk("glitch_sat", int'(glitch_count), 255);

    // clear coinciding with a glitch
    trigger_pin = 1'b1;
    step();
    trigger_pin = 1'b0;
    step();
    step();
    glitch_clear = 1'b1;
    step();
    glitch_clear = 1'b0;
    step();
    chk("glitch_clear", int'(glitch_count), 0);

    // invert after reset, then reset mid-qualify
    async_reset();
    is_invert = 1'b1;
    step();
    rst_n = 1'b1;
    n = 0;
    while (!rising_pulse && n < 50) begin
      step();
      n++;
    end
    chk("inv_rise", int'(trigger), 1);
    trigger_pin = 1'b1;
    repeat (4) step();
    async_reset();
    chk("midq_trig", int'(trigger), 0);
    is_invert = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        filter_len = FW'($urandom_range(0, 5));
        holdoff    = HW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) trigger_pin = ~trigger_pin;
      if ($urandom_range(0, 99) == 0) is_invert = ~is_invert;
      glitch_clear = ($urandom_range(0, 59) == 0);
      if (!rst_n) rst_n = 1'b1;
      if ($urandom_range(0, 499) == 0) async_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trigger_conditioner.md
# trigger_conditioner

Front-end conditioner for the external trigger pin, sitting directly upstream of the signal generator's `trigger` input. It synchronizes the raw pin into `clk`, applies optional inversion and a programmable stability filter, and enforces a programmable hold-off after every accepted edge. It outputs a clean, glitch-free trigger level plus single-cycle edge pulses, and keeps a saturating count of rejected glitches for software diagnostics.

## Interface
- `FILTER_W`, default 4: width of the filter-length field and the qualify counter.
- `HOLDOFF_W`, default 8: width of the hold-off field and the hold-off counter.
- `clk`, in, 1: system clock; the block's only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `trigger_pin`, in, 1: raw asynchronous trigger pin.
- `is_invert`, in, 1: 1 = invert the pin polarity after synchronization.
- `filter_len`, in, FILTER_W: number of extra consecutive cycles a new level must persist before it is accepted.
- `holdoff`, in, HOLDOFF_W: number of cycles after an accepted edge during which input changes are ignored.
- `glitch_clear`, in, 1: synchronous clear of `glitch_count`.
- `trigger`, out, 1: conditioned trigger level; feeds the signal generator's `trigger`.
- `rising_pulse`, out, 1: one-cycle pulse when `trigger` goes 0→1.
- `falling_pulse`, out, 1: one-cycle pulse when `trigger` goes 1→0.
- `glitch_count`, out, 8: count of rejected glitches; saturates at 255.
- `is_holdoff`, out, 1: high while the block is in hold-off.

## Operation
- Synchronizer: two flops `sync0` → `sync1`, both reset to 0.
- Conditioned sample: `s = sync1 ^ is_invert`.
- FSM states:
  - IDLE: `s == trigger`.
  - QUALIFY: `s != trigger`, candidate being timed.
  - HOLDOFF: a new level was just accepted.
- IDLE:
  - If `s != trigger`, apply the QUALIFY acceptance test in this same cycle, with `cnt` = 0.
  - Otherwise stay in IDLE with `cnt` = 0.
- QUALIFY, each cycle:
  - If `s == trigger`, this is a glitch: `cnt` ← 0, `glitch_count` increments (saturating), go to IDLE.
  - Else if `cnt >= filter_len`, accept: `trigger` ← `s`, assert the matching pulse, `cnt` ← 0, `hcnt` ← `holdoff`. Go to HOLDOFF, or to IDLE if `holdoff` == 0.
  - Otherwise `cnt` ← `cnt` + 1. `cnt` saturates at its maximum value and never wraps.
- HOLDOFF:
  - `hcnt` decrements every cycle; return to IDLE when `hcnt` reaches 0.
  - Input is ignored: no acceptance, no glitch counting, `cnt` held at 0.
  - On exit, a level that still differs starts a fresh qualification.
- `glitch_clear` has priority over an increment in the same cycle; the result is 0.
- `filter_len` and `holdoff` are sampled live.
  - A `filter_len` that drops below the current `cnt` causes acceptance on the next evaluated cycle.
  - A `holdoff` change affects only the next load of `hcnt`.
- Toggling `is_invert` behaves exactly like a pin edge.
- After reset with `is_invert` = 1 and the pin low, `s` = 1, so the block qualifies a rising edge normally. This is intended behaviour.

## Timing
- Reset values: `sync0` = 0, `sync1` = 0, `trigger` = 0, `rising_pulse` = 0, `falling_pulse` = 0, `glitch_count` = 0, `is_holdoff` = 0, `cnt` = 0, `hcnt` = 0, state = IDLE.
- Pin latency: for a pin change sampled at edge k, `trigger` and the matching pulse update at edge k+2+`filter_len`.
- Pulses are registered and high for exactly one cycle, coincident with the first cycle of the new `trigger` level.
- `is_holdoff` is high for exactly `holdoff` cycles, starting the cycle after acceptance.
- Minimum spacing between accepted edges is `filter_len`+1+`holdoff` cycles.
- Reset asserted mid-QUALIFY or mid-HOLDOFF returns every register to its reset value immediately (asynchronous). No pulse is emitted on reset.

## Test plan
- Reset: assert `rst_n` = 0 with the pin toggling → all outputs 0; after release with the pin held 0, no pulse ever occurs.
- Clean rising edge: `filter_len` = 3, `holdoff` = 0, pin 0→1 sampled at edge 10 → `trigger` = 1 from edge 15; `rising_pulse` is high for the single cycle after edge 15; `glitch_count` = 0.
- Glitch rejection: `filter_len` = 3, pin high for 2 cycles then low → `trigger` stays 0, no pulses, `glitch_count` = 1. Also `filter_len` = 0 with a 1-cycle pulse → accepted: rising then falling, spaced ≥1 cycle.
- Hold-off: `filter_len` = 1, `holdoff` = 10, pin rises then falls 4 cycles after the accepted rise → falling edge ignored while `is_holdoff` = 1; `falling_pulse` fires at hold-off exit + 2 cycles; `glitch_count` unchanged.
- Saturation and clear: 300 glitches → `glitch_count` = 255; `glitch_clear` asserted in the same cycle as a glitch → 0.
- Invert and mid-op reset: with `is_invert` = 1 and the pin low → rising accepted at edge 2+`filter_len`. Reset pulsed during QUALIFY → no pulse, state IDLE, `trigger` = 0.
